// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int FAIR_MAX_DEF = 3;

  // Sequencer states: one backend transaction in flight at most.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Requester that owns the current transaction; OWN_IF is the cleared value.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_fair_cnt.sv
// Fairness counter: counts consecutive data grants made while fetch waits,
// saturating at FAIR_MAX. Only instantiated when MEM_ARBITER_FAIR_EN is defined.
module arb_fair_cnt #(
  parameter int FAIR_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(FAIR_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q == CW'(FAIR_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one multi-cycle memory between fetch and the
// memory stage. Data has priority; define MEM_ARBITER_FAIR_EN to bound fetch
// starvation to FAIR_MAX consecutive data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FAIR_MAX = FAIR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  // data port
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  // backend
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic dm_req;
  logic fair_force;
  logic grant_dm;
  logic grant_if;

  assign dm_req = dm_rd | dm_wr;

`ifdef MEM_ARBITER_FAIR_EN
  logic fair_at_max;
  logic fair_inc;
  logic fair_clr;

  // Count data grants that bypass a waiting fetch; reset when fetch is served
  // or is not asking.
  assign fair_inc = (state_q == IDLE) && grant_dm && if_req;
  assign fair_clr = (state_q == IDLE) && (grant_if || !if_req);

  arb_fair_cnt #(.FAIR_MAX(FAIR_MAX)) u_fair_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (fair_inc),
    .clr    (fair_clr),
    .at_max (fair_at_max)
  );

  assign fair_force = fair_at_max && if_req && dm_req;
`else
  // Strict data priority; the limit only matters in the fairness build.
  logic fair_unused;
  assign fair_unused = (FAIR_MAX != 0);
  assign fair_force  = 1'b0;
`endif

  assign grant_dm = dm_req && !fair_force;
  assign grant_if = if_req && !grant_dm;

  // Next-state and backend register updates for the sequencer.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          owner_d = OWN_DM;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          wr_d    = dm_wr;            // rd+wr together is performed as a write
          err_d   = dm_rd && dm_wr;
          state_d = ISSUE;
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          wr_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_done) begin           // zero-latency backend
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and backend registers; reset abandons any outstanding transaction.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state; stalls follow the requests directly.
  always_comb begin
    mem_req   = (state_q == ISSUE);
    mem_wr    = wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    err       = err_q;
    if_done   = (state_q == RESP) && (owner_q == OWN_IF);
    dm_done   = (state_q == RESP) && (owner_q == OWN_DM);
    if_rdata  = if_done ? rdata_q : '0;
    dm_rdata  = (dm_done && !wr_q) ? rdata_q : '0;
    if_stall  = if_req && !if_done;
    dm_stall  = dm_req && !dm_done;
  end

endmodule
